// File: rtl/ctrl_pipe.sv
// Pipeline control carrier for the 5-stage MIPS core: ID/EX, EX/MEM, MEM/WB
// control registers plus load-use stall and branch flush. Optional counters: CTRL_PIPE_STATS_EN.
//
// state  | meaning (implicit, held in ID/EX content)
// IDLE   | no load in ID/EX whose rt feeds the instruction in ID
// STALL1 | load in ID/EX feeds ID; bubble goes into ID/EX, which returns to IDLE
module ctrl_pipe #(
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ALUOP_W+1:0] id_ex,
    input  logic [3:0]         id_m,
    input  logic [1:0]         id_wb,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               branch_taken,
    output logic               stall,
    output logic               flush_ifid,
    output logic               ex_reg_dst,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_alu_src,
    output logic [REG_W-1:0]   ex_rt,
    output logic               mem_branch,
    output logic               mem_read,
    output logic               mem_write,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
`ifdef CTRL_PIPE_STATS_EN
    output logic [15:0]        stall_cnt,
    output logic [15:0]        flush_cnt,
`endif
    output logic [REG_W-1:0]   wb_dest
);

    typedef struct packed {
        logic               reg_dst;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               branch;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               mem_to_reg;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
    } idex_t;

    typedef struct packed {
        logic             branch;
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] dest;
    } exmem_t;

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic [REG_W-1:0] dest;
    } memwb_t;

    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;
    logic   load_use;

    // rs is carried for the forwarding unit; id_m[3] is a spare decoder bit
    logic unused_bits;
    assign unused_bits = ^{id_m[3], idex_q.rs};

    assign load_use = idex_q.mem_read && (idex_q.rt != '0) &&
                      ((idex_q.rt == id_rs) || (idex_q.rt == id_rt));
    assign stall      = load_use && !branch_taken;
    assign flush_ifid = branch_taken;

    always_comb begin
        idex_d = '0;
        if (!branch_taken && !stall) begin
            idex_d.reg_dst   = id_ex[ALUOP_W+1];
            idex_d.alu_op    = id_ex[ALUOP_W:1];
            idex_d.alu_src   = id_ex[0];
            idex_d.branch    = id_m[2];
            idex_d.mem_read  = id_m[1];
            idex_d.mem_write = id_m[0];
            idex_d.reg_write = id_wb[1];
            // written as an if so an unknown MemtoReg settles to 0
            if (id_wb[0] == 1'b1)
                idex_d.mem_to_reg = 1'b1;
            idex_d.rs = id_rs;
            idex_d.rt = id_rt;
            idex_d.rd = id_rd;
        end
    end

    always_comb begin
        exmem_d = '0;
        if (!branch_taken) begin
            exmem_d.branch     = idex_q.branch;
            exmem_d.mem_read   = idex_q.mem_read;
            exmem_d.mem_write  = idex_q.mem_write;
            exmem_d.reg_write  = idex_q.reg_write;
            exmem_d.mem_to_reg = idex_q.mem_to_reg;
            if (idex_q.reg_write) begin
                if (idex_q.reg_dst == 1'b1)
                    exmem_d.dest = idex_q.rd;
                else
                    exmem_d.dest = idex_q.rt;
            end
        end
    end

    always_comb begin
        memwb_d            = '0;
        memwb_d.reg_write  = exmem_q.reg_write;
        memwb_d.mem_to_reg = exmem_q.mem_to_reg;
        memwb_d.dest       = exmem_q.dest;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

`ifdef CTRL_PIPE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (branch_taken && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

    assign ex_reg_dst    = idex_q.reg_dst;
    assign ex_alu_op     = idex_q.alu_op;
    assign ex_alu_src    = idex_q.alu_src;
    assign ex_rt         = idex_q.rt;
    assign mem_branch    = exmem_q.branch;
    assign mem_read      = exmem_q.mem_read;
    assign mem_write     = exmem_q.mem_write;
    assign wb_reg_write  = memwb_q.reg_write;
    assign wb_mem_to_reg = memwb_q.mem_to_reg;
    assign wb_dest       = memwb_q.dest;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: an instruction-level model predicts every
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_ctrl_pipe;

    logic       clk;
    logic       rst_n;
    logic [3:0] id_ex;
    logic [3:0] id_m;
    logic [1:0] id_wb;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       branch_taken;
    logic       stall, flush_ifid, ex_reg_dst, ex_alu_src;
    logic [1:0] ex_alu_op;
    logic [4:0] ex_rt, wb_dest;
    logic       mem_branch, mem_read, mem_write, wb_reg_write, wb_mem_to_reg;
`ifdef CTRL_PIPE_STATS_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n), .id_ex(id_ex), .id_m(id_m), .id_wb(id_wb),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .branch_taken(branch_taken),
        .stall(stall), .flush_ifid(flush_ifid), .ex_reg_dst(ex_reg_dst),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_rt(ex_rt),
        .mem_branch(mem_branch), .mem_read(mem_read), .mem_write(mem_write),
        .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
`ifdef CTRL_PIPE_STATS_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .wb_dest(wb_dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       reg_dst;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       branch, mem_read, mem_write;
        logic       reg_write, mem_to_reg;
        logic [4:0] rs, rt, rd;
    } instr_t;

    typedef struct packed {
        logic       stall, flush;
        logic       ex_reg_dst;
        logic [1:0] ex_alu_op;
        logic       ex_alu_src;
        logic [4:0] ex_rt;
        logic       mem_branch, mem_read, mem_write;
        logic       wb_reg_write, wb_mem_to_reg;
        logic [4:0] wb_dest;
`ifdef CTRL_PIPE_STATS_EN
        logic [15:0] scnt, fcnt;
`endif
    } out_t;

    typedef enum int {K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_RAND} kind_t;

    out_t   exp_q[$];
    int     vectors = 0;
    int     miscompares = 0;
    instr_t in_ex, in_mem, in_wb;
    int     m_scnt, m_fcnt;

    function automatic instr_t mk(kind_t k, int rs, int rt, int rd);
        instr_t i;
        i = '0;
        case (k)
            K_R:    begin i.reg_dst = 1; i.alu_op = 2'b10; i.reg_write = 1; end
            K_LW:   begin i.alu_src = 1; i.mem_read = 1; i.reg_write = 1; i.mem_to_reg = 1; end
            K_SW:   begin i.alu_src = 1; i.mem_write = 1; end
            K_BEQ:  begin i.alu_op = 2'b01; i.branch = 1; end
            K_ADDI: begin i.alu_src = 1; i.reg_write = 1; end
            default: i = instr_t'($urandom);
        endcase
        i.rs = 5'(rs);
        i.rt = 5'(rt);
        i.rd = 5'(rd);
        return i;
    endfunction

    // register an instruction writes when it retires
    function automatic logic [4:0] dest_of(instr_t i);
        if (!i.reg_write) return 5'd0;
        return i.reg_dst ? i.rd : i.rt;
    endfunction

    task automatic step(input instr_t ins, input logic bt, input logic rst_now,
                        output logic stalled);
        out_t e;
        @(posedge clk);
        #1;
        id_ex        = {ins.reg_dst, ins.alu_op, ins.alu_src};
        id_m         = {1'($urandom), ins.branch, ins.mem_read, ins.mem_write};
        id_wb        = {ins.reg_write, ins.mem_to_reg};
        id_rs        = ins.rs;
        id_rt        = ins.rt;
        id_rd        = ins.rd;
        branch_taken = bt;
        if (rst_now) begin
            rst_n  = 1'b0;
            in_ex  = '0;
            in_mem = '0;
            in_wb  = '0;
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            rst_n = 1'b1;
        end
        // a load whose target is read by the instruction in ID, unless $zero or flushed
        stalled = in_ex.mem_read && (in_ex.rt != 0) &&
                  (in_ex.rt == ins.rs || in_ex.rt == ins.rt) && !bt;
        e = '0;
        e.stall         = stalled;
        e.flush         = bt;
        e.ex_reg_dst    = in_ex.reg_dst;
        e.ex_alu_op     = in_ex.alu_op;
        e.ex_alu_src    = in_ex.alu_src;
        e.ex_rt         = in_ex.rt;
        e.mem_branch    = in_mem.branch;
        e.mem_read      = in_mem.mem_read;
        e.mem_write     = in_mem.mem_write;
        e.wb_reg_write  = in_wb.reg_write;
        e.wb_mem_to_reg = in_wb.mem_to_reg;
        e.wb_dest       = dest_of(in_wb);
`ifdef CTRL_PIPE_STATS_EN
        e.scnt = 16'(m_scnt);
        e.fcnt = 16'(m_fcnt);
`endif
        exp_q.push_back(e);
        if (!rst_now) begin
            if (stalled && m_scnt < 65535) m_scnt++;
            if (bt && m_fcnt < 65535) m_fcnt++;
            in_wb  = in_mem;
            in_mem = bt ? instr_t'('0) : in_ex;
            in_ex  = (bt || stalled) ? instr_t'('0) : ins;
        end
    endtask

    // re-present an instruction held in IF/ID while the pipeline stalls
    task automatic issue(input instr_t ins, input logic bt);
        logic st;
        step(ins, bt, 1'b0, st);
        for (int n = 0; n < 3 && st; n++) step(ins, 1'b0, 1'b0, st);
    endtask

    task automatic nops(input int n);
        for (int k = 0; k < n; k++) issue('0, 1'b0);
    endtask

    initial begin : monitor
        out_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '0;
                a.stall = stall; a.flush = flush_ifid;
                a.ex_reg_dst = ex_reg_dst; a.ex_alu_op = ex_alu_op;
                a.ex_alu_src = ex_alu_src; a.ex_rt = ex_rt;
                a.mem_branch = mem_branch; a.mem_read = mem_read; a.mem_write = mem_write;
                a.wb_reg_write = wb_reg_write; a.wb_mem_to_reg = wb_mem_to_reg;
                a.wb_dest = wb_dest;
`ifdef CTRL_PIPE_STATS_EN
                a.scnt = stall_cnt; a.fcnt = flush_cnt;
`endif
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL pipe_out vec %0d t=%0t: got %h expected %h",
                             vectors, $time, a, e);
                end
            end
        end
    end

    initial begin : stim
        logic   st;
        instr_t cur;
        kind_t  k;
        rst_n = 1'b0; id_ex = '0; id_m = '0; id_wb = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; branch_taken = 1'b0;
        in_ex = '0; in_mem = '0; in_wb = '0; m_scnt = 0; m_fcnt = 0;

        step('0, 1'b0, 1'b1, st);
        step('0, 1'b0, 1'b1, st);
        // R-type to rd=8
        issue(mk(K_R, 1, 9, 8), 1'b0);
        nops(3);
        // load-use on r4
        issue(mk(K_LW, 1, 4, 0), 1'b0);
        issue(mk(K_R, 4, 5, 6), 1'b0);
        nops(3);
        // load to $zero never stalls
        issue(mk(K_LW, 2, 0, 0), 1'b0);
        issue(mk(K_R, 0, 0, 7), 1'b0);
        nops(3);
        // taken branch resolved in MEM
        issue(mk(K_BEQ, 1, 2, 0), 1'b0);
        issue(mk(K_R, 3, 4, 5), 1'b0);
        issue(mk(K_ADDI, 3, 6, 0), 1'b1);
        nops(3);
        // hazard and flush together
        issue(mk(K_LW, 1, 3, 0), 1'b0);
        issue(mk(K_R, 3, 2, 9), 1'b1);
        nops(3);
        // reset with sw in EX/MEM and lw in MEM/WB
        issue(mk(K_LW, 1, 10, 0), 1'b0);
        issue(mk(K_SW, 1, 11, 0), 1'b0);
        issue(mk(K_R, 1, 2, 12), 1'b0);
        step('0, 1'b0, 1'b1, st);
        step('0, 1'b0, 1'b1, st);
        nops(2);

        cur = '0;
        st  = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!st) begin
                k   = kind_t'($urandom_range(0, 5));
                cur = mk(k, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 31));
            end
            if ($urandom_range(0, 39) == 0)
                step('0, 1'b0, 1'b1, st);
            else
                step(cur, ($urandom_range(0, 7) == 0), 1'b0, st);
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer side of the main control decoder: accepts the ID-stage EX/M/WB control bundles.
- Carries the bundles through the ID/EX, EX/MEM and MEM/WB pipeline registers, and unpacks them into per-stage control strobes for the datapath.
- Owns load-use hazard detection (stall plus bubble insertion) and branch flush for the 5-stage MIPS pipeline.

Parameters:
- REG_W, 5, register-index width.
- ALUOP_W, 2, ALUOp field width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_ex  in  4  EX bundle from decoder: [3] RegDst, [2:1] ALUOp, [0] ALUSrc.
- id_m  in  4  M bundle: [2] Branch, [1] MemRead, [0] MemWrite; [3] ignored.
- id_wb  in  2  WB bundle: [1] RegWrite, [0] MemtoReg.
- id_rs  in  REG_W  rs field of the instruction in ID.
- id_rt  in  REG_W  rt field of the instruction in ID.
- id_rd  in  REG_W  rd field of the instruction in ID.
- branch_taken  in  1  from MEM stage: branch resolved taken this cycle.
- stall  out  1  hold PC and IF/ID (combinational).
- flush_ifid  out  1  zero IF/ID (equals branch_taken).
- ex_reg_dst  out  1  ID/EX RegDst.
- ex_alu_op  out  ALUOP_W  ID/EX ALUOp.
- ex_alu_src  out  1  ID/EX ALUSrc.
- ex_rt  out  REG_W  ID/EX rt.
- mem_branch  out  1  EX/MEM Branch.
- mem_read  out  1  EX/MEM MemRead.
- mem_write  out  1  EX/MEM MemWrite.
- wb_reg_write  out  1  MEM/WB RegWrite.
- wb_mem_to_reg  out  1  MEM/WB MemtoReg.
- wb_dest  out  REG_W  MEM/WB destination register.

Behaviour:
- Reset: all pipeline registers clear asynchronously on rst_n low, so every registered output is 0. Reset mid-stream discards all in-flight bundles with no completion. First capture occurs on the first rising clk after rst_n is released.
- Stages:
  - ID/EX captures {id_ex, id_m[2:0], id_wb, id_rs, id_rt, id_rd}.
  - EX/MEM captures {M, WB, dest}.
  - MEM/WB captures {WB, dest}.
  - Latency is 1 cycle per stage: a bundle presented in ID at cycle N appears on ex_* at N+1, mem_* at N+2 and wb_* at N+3.
- Destination: dest = RegDst ? rd : rt, resolved at the ID/EX to EX/MEM transfer. An X on RegDst is treated as 0. dest is forced to 0 when RegWrite=0.
- MemtoReg: an X on MemtoReg is forced to 0 when captured.
- Load-use hazard: stall = ex_mem_read_q & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)). Here ex_mem_read_q is the MemRead bit currently held in ID/EX. When stall=1:
  - ID/EX loads an all-zero bubble (rs/rt/rd zeroed).
  - EX/MEM and MEM/WB advance normally.
- Stall duration: stall is asserted for exactly one cycle per load-use pair, because the bubble clears ex_mem_read_q.
- Flush (branch_taken=1):
  - ID/EX and EX/MEM load all-zero bubbles.
  - MEM/WB advances normally, so the branch itself retires harmlessly.
  - flush_ifid = 1 in the same cycle.
- Priority: when flush and stall occur in the same cycle, flush wins: stall is forced to 0 and bubbles are inserted as for flush.
- Back-to-back loads with dependent consumers produce one stall each; the stall state machine is implicit (IDLE to STALL1 to IDLE through ID/EX content).
- $zero: register 0 as a load destination never stalls.

Optional Feature:
- Macro: CTRL_PIPE_STATS_EN.
- When defined, adds outputs stall_cnt[15:0] and flush_cnt[15:0]:
  - Each counts cycles with stall=1 or branch_taken=1 respectively.
  - Each saturates at 16'hFFFF and resets to 0 on rst_n low.
- When undefined, these ports and their counters do not exist. All other behaviour is identical in both cases.

Test Plan:
- R-type (id_ex=4'b1100, id_m=0, id_wb=2'b10, rd=5'd8, rt=5'd9) -> ex_reg_dst=1 and ex_alu_op=2'b10 at N+1; wb_reg_write=1, wb_dest=8 at N+3; stall=0 throughout.
- lw rt=5'd4, then add with rs=5'd4 -> stall=1 for exactly one cycle; ex_* all 0 the next cycle; add reaches EX one cycle late; lw arrives at wb_mem_to_reg=1, wb_dest=4.
- lw rt=0, then consumer rs=0 -> stall=0 throughout.
- beq (id_m=3'b100), then two ALU instrs; branch_taken=1 when beq is in MEM -> ex_* and mem_* zero the next cycle, flush_ifid=1; beq reaches WB with wb_reg_write=0, wb_dest=0.
- Load-use hazard and branch_taken in the same cycle -> stall=0, both bubbles inserted.
- rst_n low mid-stream (sw in EX/MEM, lw in MEM/WB) -> all outputs 0 immediately, without waiting for clk. With CTRL_PIPE_STATS_EN defined, the counters also read 0 and increment only after reset release.
